btb_file: RTL and testbench

BTB_FILE -- requirements
Module: btb_file

---
 rtl/btb_file_pkg.sv | 12 +
 rtl/btb_file_flush_ctrl.sv | 51 +++++
 rtl/btb_file.sv | 71 +++++++
 tb/tb_btb_file.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_file_pkg.sv
// Shared BTB geometry, valid-bit positions and flush FSM encodings.
package btb_file_pkg;
  localparam int BTB_SETS  = 8;
  localparam int BTB_SET_W = 128;
  localparam int VALID1    = 127;
  localparam int VALID2    = 63;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } flush_state_e;
endpackage

// File: rtl/btb_file_flush_ctrl.sv
// Invalidate-sweep sequencer: walks every set once, one per cycle, after a flush request.
module btb_flush_ctrl
  import btb_file_pkg::*;
#(
  parameter int NUM_SETS = BTB_SETS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_all,
  output logic                        busy,
  output logic                        sweep_en,
  output logic [$clog2(NUM_SETS)-1:0] sweep_idx
);
  localparam int IDX_W = $clog2(NUM_SETS);

  flush_state_e     r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_busy;

  // flush_all is only sampled in IDLE, so a request mid-sweep cannot restart it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_all) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(NUM_SETS - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign sweep_en  = r_busy;
  assign sweep_idx = r_cnt;
endmodule

// File: rtl/btb_file.sv
// Flop-based 2-way BTB set file with write-to-read forwarding and a sequential invalidate sweep.
module btb_file
  import btb_file_pkg::*;
#(
  parameter int NUM_SETS = BTB_SETS,
  parameter int SET_W    = BTB_SET_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_SETS)-1:0] read_index,
  output logic [SET_W-1:0]            read_set,
  input  logic [$clog2(NUM_SETS)-1:0] update_index,
  output logic [SET_W-1:0]            update_set,
  output logic [NUM_SETS-1:0]         LRU,
  input  logic                        write_en,
  input  logic [SET_W-1:0]            write_set,
  input  logic                        next_LRU_write,
  input  logic                        flush_all,
  output logic                        busy
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam logic [SET_W-1:0] VMASK =
    ~((SET_W'(1) << VALID1) | (SET_W'(1) << VALID2));

  logic [NUM_SETS-1:0][SET_W-1:0] r_sets;
  logic [NUM_SETS-1:0]            r_lru;

  logic             w_busy, w_sweep_en, w_wr, w_fwd;
  logic [IDX_W-1:0] w_sweep_idx;
  logic [SET_W-1:0] w_rd_raw, w_up_raw;

  btb_flush_ctrl #(.NUM_SETS(NUM_SETS)) u_flush (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_all (flush_all),
    .busy      (w_busy),
    .sweep_en  (w_sweep_en),
    .sweep_idx (w_sweep_idx)
  );

  assign w_wr = write_en & ~w_busy;

  // Sweep has priority; while it runs w_wr is already low, so there is never a same-set collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sets <= '0;
      r_lru  <= '0;
    end else begin
      for (int i = 0; i < NUM_SETS; i++) begin
        if (w_sweep_en && w_sweep_idx == IDX_W'(i)) begin
          r_sets[i][VALID1] <= 1'b0;
          r_sets[i][VALID2] <= 1'b0;
          r_lru[i]          <= 1'b0;
        end else if (w_wr && update_index == IDX_W'(i)) begin
          r_sets[i] <= write_set;
          r_lru[i]  <= next_LRU_write;
        end
      end
    end
  end

  // update_set deliberately has no bypass: it feeds the merge logic that produces write_set
  assign w_fwd    = w_wr && (read_index == update_index);
  assign w_rd_raw = w_fwd ? write_set : r_sets[read_index];
  assign w_up_raw = r_sets[update_index];

  assign read_set   = w_busy ? (w_rd_raw & VMASK) : w_rd_raw;
  assign update_set = w_busy ? (w_up_raw & VMASK) : w_up_raw;
  assign LRU        = r_lru;
  assign busy       = w_busy;
endmodule

// File: tb/tb_btb_file.sv
// Bench for btb_file: vector table for write/forward behaviour plus sweep, collision and reset sequences.
`timescale 1ns/1ps
module tb_btb_file;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   read_index = '0;
  logic [127:0] read_set;
  logic [2:0]   update_index = '0;
  logic [127:0] update_set;
  logic [7:0]   LRU;
  logic         write_en = 1'b0;
  logic [127:0] write_set = '0;
  logic         next_LRU_write = 1'b0;
  logic         flush_all = 1'b0;
  logic         busy;

  always #5 clk = ~clk;

  btb_file dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_index     (read_index),
    .read_set       (read_set),
    .update_index   (update_index),
    .update_set     (update_set),
    .LRU            (LRU),
    .write_en       (write_en),
    .write_set      (write_set),
    .next_LRU_write (next_LRU_write),
    .flush_all      (flush_all),
    .busy           (busy)
  );

  typedef struct {
    int           kind;  // 0 read_set, 1 update_set, 2 LRU, 3 busy
    string        name;
    logic [127:0] exp;
  } sb_t;

  typedef struct {
    logic         we;
    logic [2:0]   ui;
    logic [127:0] ws;
    logic         nl;
    logic [2:0]   ri;
    logic [127:0] e_rd;
    logic [127:0] e_up;
    logic [7:0]   e_lru;
  } vec_t;

  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[5];

  function automatic logic [127:0] pat(input int i);
    return {1'b1, 63'h0ABC_0000_0000_0000 + 63'(i), 1'b1, 63'h0DEF_0000_0000_0000 + 63'(i * 7)};
  endfunction

  function automatic logic [127:0] mv(input logic [127:0] x);
    logic [127:0] r;
    r = x;
    r[127] = 1'b0;
    r[63]  = 1'b0;
    return r;
  endfunction

  task automatic expect_v(input int kind, input string name, input logic [127:0] exp);
    sb_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic check_now();
    sb_t          e;
    logic [127:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0:       act = read_set;
        1:       act = update_set;
        2:       act = {120'd0, LRU};
        default: act = {127'd0, busy};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
  task automatic cyc();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input int idx, input logic [127:0] d, input logic nl);
    write_en = 1'b1; update_index = 3'(idx); write_set = d; next_LRU_write = nl;
    cyc();
    write_en = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 8; i++) write_one(i, pat(i), 1'b1);
  endtask

  int nb;

  initial begin
    tbl[0] = '{1'b1, 3'd3, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A55A, 1'b1, 3'd3,
               128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A55A, 128'd0, 8'h00};
    tbl[1] = '{1'b0, 3'd3, 128'd0, 1'b0, 3'd3,
               128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A55A,
               128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A55A, 8'h08};
    tbl[2] = '{1'b1, 3'd0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0, 3'd3,
               128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A55A, 128'd0, 8'h08};
    tbl[3] = '{1'b1, 3'd0, 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF, 1'b1, 3'd0,
               128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF,
               128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 8'h08};
    tbl[4] = '{1'b0, 3'd0, 128'd0, 1'b0, 3'd0,
               128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF,
               128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF, 8'h09};

    // Reset state
    #12;
    expect_v(3, "busy_in_reset", 128'd0);
    check_now();
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_index = 3'd5;
    expect_v(0, "s1_read5", 128'd0);
    expect_v(2, "s1_lru", 128'd0);
    expect_v(3, "s1_busy", 128'd0);
    cyc();

    // Write / forward vectors
    for (int v = 0; v < 5; v++) begin
      write_en = tbl[v].we; update_index = tbl[v].ui; write_set = tbl[v].ws;
      next_LRU_write = tbl[v].nl; read_index = tbl[v].ri;
      expect_v(0, $sformatf("vec%0d_rd", v), tbl[v].e_rd);
      expect_v(1, $sformatf("vec%0d_up", v), tbl[v].e_up);
      expect_v(2, $sformatf("vec%0d_lru", v), {120'd0, tbl[v].e_lru});
      cyc();
    end
    write_en = 1'b0;

    // Full sweep
    fill_all();
    expect_v(2, "s3_lru_full", {120'd0, 8'hFF});
    flush_all = 1'b1;
    cyc();
    flush_all = 1'b0;
    nb = 0;
    for (int k = 1; k <= 12; k++) begin
      read_index = 3'd0; update_index = 3'd3;
      if (k == 1) begin
        expect_v(0, "s3_rd_masked", mv(pat(0)));
        expect_v(1, "s3_up_masked", mv(pat(3)));
      end
      @(negedge clk);
      if (busy) nb++;
      check_now();
      @(posedge clk); #1;
    end
    chk_int("s3_busy_cycles", nb, 8);
    for (int i = 0; i < 8; i++) begin
      read_index = 3'(i);
      expect_v(0, $sformatf("s3_set%0d", i), mv(pat(i)));
      cyc();
    end
    expect_v(2, "s3_lru_clr", 128'd0);
    cyc();

    // Writes and flush requests during a sweep
    fill_all();
    flush_all = 1'b1;
    cyc();
    flush_all = 1'b0;
    nb = 0;
    for (int k = 1; k <= 12; k++) begin
      write_en = (k == 4); update_index = 3'd2; next_LRU_write = 1'b1;
      write_set = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      flush_all = (k == 6);
      if (k == 8) expect_v(3, "s4_busy_c8", 128'd1);
      if (k == 9) expect_v(3, "s4_busy_c9", 128'd0);
      @(negedge clk);
      if (busy) nb++;
      check_now();
      @(posedge clk); #1;
    end
    write_en = 1'b0; flush_all = 1'b0;
    chk_int("s4_busy_cycles", nb, 8);
    read_index = 3'd2;
    expect_v(0, "s4_set2", mv(pat(2)));
    expect_v(2, "s4_lru", 128'd0);
    cyc();

    // flush_all with a write in the same idle cycle
    write_en = 1'b1; update_index = 3'd7; next_LRU_write = 1'b1; read_index = 3'd7;
    write_set = {1'b1, 63'h1111, 1'b1, 63'h2222};
    flush_all = 1'b1;
    expect_v(0, "s5_fwd", {1'b1, 63'h1111, 1'b1, 63'h2222});
    cyc();
    write_en = 1'b0; flush_all = 1'b0;
    nb = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 7) expect_v(2, "s5_lru_c7", {120'd0, 8'h80});
      if (k == 8) expect_v(1, "s5_up7_c8", {1'b0, 63'h1111, 1'b0, 63'h2222});
      @(negedge clk);
      if (busy) nb++;
      check_now();
      @(posedge clk); #1;
    end
    chk_int("s5_busy_cycles", nb, 8);
    read_index = 3'd7;
    expect_v(0, "s5_set7", {1'b0, 63'h1111, 1'b0, 63'h2222});
    expect_v(2, "s5_lru", 128'd0);
    cyc();

    // Reset in the middle of a sweep
    fill_all();
    flush_all = 1'b1;
    cyc();
    flush_all = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    read_index = 3'd7; update_index = 3'd2;
    #1;
    expect_v(3, "s6_busy_rst", 128'd0);
    expect_v(2, "s6_lru_rst", 128'd0);
    expect_v(0, "s6_rd_rst", 128'd0);
    expect_v(1, "s6_up_rst", 128'd0);
    check_now();
    @(posedge clk); #1;
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      read_index = 3'(i);
      expect_v(0, $sformatf("s6_set%0d", i), 128'd0);
      @(negedge clk);
      if (busy) nb++;
      check_now();
      @(posedge clk); #1;
    end
    chk_int("s6_busy_after", nb, 0);
    write_one(4, pat(4), 1'b1);
    read_index = 3'd4;
    expect_v(0, "s6_idle_write", pat(4));
    expect_v(2, "s6_idle_lru", {120'd0, 8'h10});
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
